// File: rtl/rs_pipeline_pkg.sv
// rs_pipeline_pkg: shared sizing helpers for the relay-station pipeline tail (optional RS_TAIL_OVERFLOW_DET_EN)
package rs_pipeline_pkg;

  // Slack needed to cover data in flight forward plus full_n travelling back.
  function automatic int rs_reserve(input int level);
    return 2 * level + 2;
  endfunction

  function automatic int rs_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int rs_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

`ifdef RS_TAIL_OVERFLOW_DET_EN
  localparam bit RS_OVF_DET_EN = 1'b1;
`else
  localparam bit RS_OVF_DET_EN = 1'b0;
`endif

endpackage

// File: rtl/rs_tail_fifo_mem.sv
// rs_tail_fifo_mem: storage array with synchronous write and asynchronous read
module rs_tail_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset; validity is tracked by the controller's count.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rs_pipeline_tail_fifo.sv
// rs_pipeline_tail_fifo: FWFT tail FIFO with round-trip slack and registered full_n (optional RS_TAIL_OVERFLOW_DET_EN adds overflow_sticky)
module rs_pipeline_tail_fifo
  import rs_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_LEVEL = 10,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read
`ifdef RS_TAIL_OVERFLOW_DET_EN
  ,
  output logic                  overflow_sticky
`endif
);

  localparam int RESERVE = rs_reserve(PIPE_LEVEL);
  localparam int PW      = rs_ptr_w(DEPTH);
  localparam int CW      = rs_cnt_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - RESERVE);
  localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

  if (DEPTH <= RESERVE) begin : g_depth_check
    $error("rs_pipeline_tail_fifo: DEPTH must exceed RESERVE (2*PIPE_LEVEL+2)");
  end

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  full_n_q, full_n_d, empty_n_q, empty_n_d;
  logic                  push, pop, drop;
  logic [DATA_WIDTH-1:0] rdata;

  // A pop frees a slot in the same cycle, so push is legal even at full.
  always_comb begin
    pop       = if_read && (count_q != '0);
    push      = if_write && ((count_q < DEPTH_C) || pop);
    drop      = if_write && !push;
    count_d   = (push && !pop) ? count_q + CW'(1) :
                (!push && pop) ? count_q - CW'(1) : count_q;
    wr_ptr_d  = !push ? wr_ptr_q : (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d  = !pop ? rd_ptr_q : (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
    full_n_d  = count_d < THRESH_C;
    empty_n_d = count_d != '0;
  end

  // Pointer, occupancy and flag registers; flags come from next-state count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_n_q  <= 1'b0;
      empty_n_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  rs_tail_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (PW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(if_din),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_dout    = empty_n_q ? rdata : '0;

`ifdef RS_TAIL_OVERFLOW_DET_EN
  logic ovf_q;

  // Sticky record of any dropped write; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_q | drop;
  end

  assign overflow_sticky = ovf_q;

  a_no_drop: assert property (@(posedge clk) disable iff (!rst_n) !drop)
    else $error("rs_pipeline_tail_fifo: write dropped at full (RS_OVF_DET_EN=%0b)", RS_OVF_DET_EN);
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_rs_pipeline_tail_fifo.sv
// tb_rs_pipeline_tail_fifo: scoreboard bench for rs_pipeline_tail_fifo with queue-based reference model
module tb_rs_pipeline_tail_fifo;

  localparam int DW      = 32;
  localparam int PL      = 10;
  localparam int DEPTH   = 32;
  localparam int RESERVE = 2 * PL + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          if_full_n, if_empty_n;
  logic [DW-1:0] if_dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            mcount = 0;
  logic          exp_full_n = 1'b0;
  logic          exp_empty_n = 1'b0;
  logic          exp_ovf = 1'b0;

`ifdef RS_TAIL_OVERFLOW_DET_EN
  logic overflow_sticky;
`endif

  rs_pipeline_tail_fifo #(
    .DATA_WIDTH(DW),
    .PIPE_LEVEL(PL),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_din    (din),
    .if_write  (wr),
    .if_full_n (if_full_n),
    .if_dout   (if_dout),
    .if_empty_n(if_empty_n),
    .if_read   (rd)
`ifdef RS_TAIL_OVERFLOW_DET_EN
    ,
    .overflow_sticky(overflow_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the FIFO as a queue of accepted words and an occupancy count.
  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit p = rd && (mcount > 0);
      automatic bit w = wr && ((mcount < DEPTH) || p);
      if (w) exp_q.push_back(din);
      if (wr && !w) exp_ovf = 1'b1;
      mcount      = mcount + int'(w) - int'(p);
      exp_full_n  = mcount < DEPTH - RESERVE;
      exp_empty_n = mcount != 0;
    end
  end

  // Monitor: compares flags every cycle and pops the scoreboard on each DUT pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_full_n", {31'b0, if_full_n}, '0);
      check("rst_empty_n", {31'b0, if_empty_n}, '0);
      check("rst_dout", if_dout, '0);
    end else begin
      check("full_n", {31'b0, if_full_n}, {31'b0, exp_full_n});
      check("empty_n", {31'b0, if_empty_n}, {31'b0, exp_empty_n});
`ifdef RS_TAIL_OVERFLOW_DET_EN
      check("ovf_sticky", {31'b0, overflow_sticky}, {31'b0, exp_ovf});
`endif
      if (rd && if_empty_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_underflow: DUT popped %h with scoreboard empty at %0t", if_dout, $time);
        end else begin
          check("pop_data", if_dout, exp_q.pop_front());
        end
      end else if (if_empty_n && exp_q.size() > 0) begin
        check("head_data", if_dout, exp_q[0]);
      end
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    wr  = w;
    din = d;
    rd  = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (mcount > 0 && budget > 0) begin
      step(1'b0, '0, 1'b1);
      budget--;
    end
    step(1'b0, '0, 1'b0);
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: model count %0d required 0", mcount);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    step(1'b1, 32'hA5A5_0001, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1);
    idle(2);

    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 32'h0000_DEAD, 1'b0);
    step(1'b1, 32'h0000_BEEF, 1'b1);
    idle(1);
    drain();

    for (int i = 0; i < 9; i++) step(1'b1, 32'h100 + DW'(i), 1'b0);
    step(1'b1, 32'h1FF, 1'b1);
    idle(1);
    drain();

    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    idle(1);

    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 2 == 0) ? 85 : 30;
      pr = (ph % 2 == 0) ? 30 : 85;
      for (int i = 0; i < 300; i++)
        step(($urandom_range(0, 99) < pw), $urandom, ($urandom_range(0, 99) < pr));
    end
    drain();

    for (int i = 0; i < 15; i++) step(1'b1, 32'h200 + DW'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_empty_n", {31'b0, if_empty_n}, '0);
    check("async_full_n", {31'b0, if_full_n}, '0);
    check("async_dout", if_dout, '0);
    exp_q.delete();
    mcount      = 0;
    exp_full_n  = 1'b0;
    exp_empty_n = 1'b0;
    exp_ovf     = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    step(1'b1, 32'h1234_5678, 1'b0);
    idle(2);
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
